// File: rtl/ir_dispatch_if.sv
// Dispatcher <-> environment bundle: program start, microsequencer handshake,
// instruction memory read port and status flags.
interface ir_dispatch_if #(
  parameter int PC_W = 8
);
  logic            start;
  logic            seq_done;
  logic [7:0]      mem_data;
  logic            mem_valid;
  logic            mem_req;
  logic [PC_W-1:0] pc;
  logic [5:0]      ir_out;
  logic            busy;
  logic            halted;
  logic            illegal;
  logic            wd_err;

  modport master (
    input  start, seq_done, mem_data, mem_valid,
    output mem_req, pc, ir_out, busy, halted, illegal, wd_err
  );

  modport slave (
    output start, seq_done, mem_data, mem_valid,
    input  mem_req, pc, ir_out, busy, halted, illegal, wd_err
  );
endinterface

// File: rtl/ir_dispatch.sv
// Instruction fetch/decode/dispatch FSM feeding a microsequencer IR input.
// Optional watchdog on the wait states is enabled by defining DISPATCH_WATCHDOG_EN.
module ir_dispatch #(
  parameter int PC_W     = 8,
  parameter int WD_LIMIT = 8
) (
  input logic           clk,
  input logic           rst,
  ir_dispatch_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_MEMRD  = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_FETCH = 6'd1;
  localparam logic [5:0] OP_HALT  = 6'd56;

  if (PC_W < 1 || WD_LIMIT < 1) begin : g_param_chk
    $error("ir_dispatch: PC_W and WD_LIMIT must be at least 1");
  end

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [5:0]      ir_q, ir_d;
  logic [5:0]      op_q;
  logic            op_load;
  logic            mem_req_q, busy_q, halted_q;
  logic            illegal_q, illegal_d;
  logic            wd_expire;
  logic            unused_mem_hi;

  assign unused_mem_hi = ^bus.mem_data[7:6];

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'd1, 6'd4, 6'd8, 6'd12, 6'd14, 6'd16, 6'd18, 6'd21,
                      6'd24, 6'd27, 6'd30, 6'd33, [6'd36:6'd52],
                      6'd54, 6'd55, 6'd56};
  endfunction

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    op_load   = 1'b0;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH:  if (bus.seq_done) state_d = S_MEMRD;
      S_MEMRD: begin
        if (bus.mem_valid) begin
          op_load = 1'b1;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_legal(op_q)) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC:   if (bus.seq_done) state_d = (op_q == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    if (wd_expire) state_d = S_HALT;

    // Outputs are registered, so they are computed from the state being entered.
    case (state_d)
      S_FETCH: ir_d = OP_FETCH;
      S_EXEC:  ir_d = op_q;
      S_HALT:  ir_d = OP_HALT;
      default: ir_d = 6'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mem_req_q <= (state_d == S_MEMRD);
      busy_q    <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q  <= (state_d == S_HALT);
      illegal_q <= illegal_d;
    end
  end

  // Opcode is only consumed in DECODE/EXEC, always after a load.
  always_ff @(posedge clk) begin
    if (op_load) op_q <= bus.mem_data[5:0];
  end

`ifdef DISPATCH_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_err_q;
  logic            waiting;

  always_comb begin
    waiting   = (((state_q == S_FETCH) || (state_q == S_EXEC)) && !bus.seq_done) ||
                ((state_q == S_MEMRD) && !bus.mem_valid);
    wd_expire = waiting && (wd_cnt_q == WD_W'(WD_LIMIT - 1));
    wd_cnt_d  = (waiting && !wd_expire) ? wd_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_q | wd_expire;
    end
  end

  assign bus.wd_err = wd_err_q;
`else
  assign wd_expire  = 1'b0;
  assign bus.wd_err = 1'b0;
`endif

  assign bus.mem_req = mem_req_q;
  assign bus.pc      = pc_q;
  assign bus.ir_out  = ir_q;
  assign bus.busy    = busy_q;
  assign bus.halted  = halted_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_ir_dispatch.sv
// Directed bench for ir_dispatch: reset, program flow, illegal opcodes, PC wrap,
// mid-EXEC reset and the wait-state watchdog (either build of DISPATCH_WATCHDOG_EN).
module tb_ir_dispatch;

  logic clk = 1'b0;
  logic rst;
  int   nvec  = 0;
  int   nfail = 0;

  ir_dispatch_if #(.PC_W(8)) bus ();

  ir_dispatch #(.PC_W(8), .WD_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ir"},      32'(bus.ir_out),  0);
    chk({tag, "_pc"},      32'(bus.pc),      0);
    chk({tag, "_req"},     32'(bus.mem_req), 0);
    chk({tag, "_busy"},    32'(bus.busy),    0);
    chk({tag, "_halted"},  32'(bus.halted),  0);
    chk({tag, "_illegal"}, 32'(bus.illegal), 0);
    chk({tag, "_wderr"},   32'(bus.wd_err),  0);
  endtask

  // Starts in FETCH, ends in the state after DECODE (EXEC or HALT).
  task automatic run_instr(input logic [7:0] d, input logic [7:0] exp_pc, input int exp_ir);
    logic [7:0] nxt_pc;
    nxt_pc = exp_pc + 8'd1;
    chk("fetch_ir", 32'(bus.ir_out), 1);
    bus.seq_done = 1'b1; tick(); bus.seq_done = 1'b0;
    chk("memrd_req", 32'(bus.mem_req), 1);
    chk("memrd_ir",  32'(bus.ir_out),  0);
    chk("memrd_pc",  32'(bus.pc),      32'(exp_pc));
    bus.mem_valid = 1'b1; bus.mem_data = d; tick(); bus.mem_valid = 1'b0;
    chk("decode_req", 32'(bus.mem_req), 0);
    chk("decode_pc",  32'(bus.pc),      32'(nxt_pc));
    tick();
    chk("exec_ir", 32'(bus.ir_out), 32'(exp_ir));
  endtask

  task automatic feed(input logic [7:0] d);
    bus.seq_done = 1'b1; tick(); bus.seq_done = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_data = d; tick(); bus.mem_valid = 1'b0;
    tick();
  endtask

  task automatic seq_pulse();
    bus.seq_done = 1'b1; tick(); bus.seq_done = 1'b0;
  endtask

  task automatic reset_and_start();
    rst = 1'b1; #2; rst = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.seq_done  = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = 8'h00;
    #1 rst = 1'b1;
    tick(); tick();
    chk_reset("por");
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(bus.busy), 0);

    // First instruction: 3-cycle FETCH, opcode 4
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("fetch_busy", 32'(bus.busy),    1);
    chk("fetch_req",  32'(bus.mem_req), 0);
    bus.mem_valid = 1'b1; bus.mem_data = 8'h38; tick(); bus.mem_valid = 1'b0;
    chk("fetch_hold_ir",  32'(bus.ir_out),  1);
    chk("fetch_hold_req", 32'(bus.mem_req), 0);
    tick();
    run_instr(8'h04, 8'd0, 4);
    chk("exec_pc",   32'(bus.pc),   1);
    chk("exec_busy", 32'(bus.busy), 1);
    bus.mem_valid = 1'b1; tick(); bus.mem_valid = 1'b0;
    chk("exec_hold_ir", 32'(bus.ir_out), 4);

    // Rest of program {4,36,56}
    seq_pulse(); run_instr(8'd36, 8'd1, 36);
    seq_pulse(); run_instr(8'd56, 8'd2, 56);
    seq_pulse();
    chk("prog_halted", 32'(bus.halted),  1);
    chk("prog_ir",     32'(bus.ir_out),  56);
    chk("prog_pc",     32'(bus.pc),      3);
    chk("prog_busy",   32'(bus.busy),    0);
    chk("prog_illeg",  32'(bus.illegal), 0);
    bus.start = 1'b1; bus.seq_done = 1'b1; tick(); tick();
    bus.start = 1'b0; bus.seq_done = 1'b0;
    chk("halt_stay",    32'(bus.halted), 1);
    chk("halt_stay_ir", 32'(bus.ir_out), 56);

    // Async reset out of HALT, then reset priority over simultaneous inputs
    rst = 1'b1; #2;
    chk_reset("halt_rst");
    bus.start = 1'b1; bus.seq_done = 1'b1; bus.mem_valid = 1'b1;
    tick();
    chk("rstpri_busy", 32'(bus.busy),    0);
    chk("rstpri_req",  32'(bus.mem_req), 0);
    chk("rstpri_ir",   32'(bus.ir_out),  0);
    rst = 1'b0; bus.seq_done = 1'b0; bus.mem_valid = 1'b0;
    tick(); bus.start = 1'b0;

    // Opcode 1 and 52 are legal; reset mid-EXEC on opcode 18
    run_instr(8'd1,  8'd0, 1);  seq_pulse();
    run_instr(8'd52, 8'd1, 52); seq_pulse();
    run_instr(8'd18, 8'd2, 18);
    rst = 1'b1; #2;
    chk_reset("exec_rst");
    #1 rst = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    run_instr(8'hC4, 8'd0, 4);

    // Illegal opcodes
    reset_and_start();
    run_instr(8'h02, 8'd0, 56);
    chk("ill2_flag",   32'(bus.illegal), 1);
    chk("ill2_halted", 32'(bus.halted),  1);
    chk("ill2_busy",   32'(bus.busy),    0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("ill2_stay",    32'(bus.halted),  1);
    chk("ill2_stay_ir", 32'(bus.ir_out),  56);
    reset_and_start();
    run_instr(8'd53, 8'd0, 56);
    chk("ill53_flag", 32'(bus.illegal), 1);

    // PC wrap 255 -> 0
    reset_and_start();
    for (int i = 0; i < 255; i++) begin
      feed(8'h44);
      seq_pulse();
    end
    run_instr(8'h44, 8'd255, 4);
    chk("wrap_pc", 32'(bus.pc), 0);
    seq_pulse();
    run_instr(8'h08, 8'd0, 8);
    chk("wrap_cont_pc", 32'(bus.pc), 1);

    // EXEC wait without seq_done
    seq_pulse();
    run_instr(8'd18, 8'd1, 18);
    repeat (7) tick();
    chk("wd_pre_ir",     32'(bus.ir_out), 18);
    chk("wd_pre_halted", 32'(bus.halted), 0);
    chk("wd_pre_err",    32'(bus.wd_err), 0);
    tick();
`ifdef DISPATCH_WATCHDOG_EN
    chk("wd_err",    32'(bus.wd_err), 1);
    chk("wd_halted", 32'(bus.halted), 1);
    chk("wd_ir",     32'(bus.ir_out), 56);
    chk("wd_busy",   32'(bus.busy),   0);
`else
    chk("wd_err",    32'(bus.wd_err), 0);
    chk("wd_halted", 32'(bus.halted), 0);
    chk("wd_ir",     32'(bus.ir_out), 18);
    chk("wd_busy",   32'(bus.busy),   1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
